// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
//   Once per frame, works out the ball's motion vector and sends it to the
//   ball position register. Keyboard direction keys and the space (pause) key
//   are latched as they arrive. On each frame tick the FSM resolves them
//   against the pause state and the wall limits. It then drives a registered
//   motion vector with a one-cycle Update strobe.
//
// Ports
//   Clk          system clock, all state on its rising edge
//   Reset        asynchronous active-low reset
//   frame_clk    frame-rate pulse, asynchronous to Clk
//   keycode[7:0] current USB keycode (0 = none)
//   BallX/BallY  current ball centre (10-bit)
//   BallS        ball half-size (10-bit)
//   Motion_X/Y   two's-complement motion, stable between APPLY cycles
//   Update       one-Clk strobe, the datapath adds Motion_X/Y on this cycle
//   Paused       high while motion is frozen
//   Busy         high in EVAL and APPLY
//   o_dbg_state  current FSM state (IDLE=0, EVAL=1, APPLY=2)
//
// Handshake: Update is a single-cycle, unacknowledged strobe. Motion_X/Y are
// valid whenever Update is high and hold until the next APPLY. The sink
// cannot stall the controller.
// ---------------------------------------------------------------------------
module ball_motion_ctrl #(
  parameter int         X_MIN = 0,
  parameter int         X_MAX = 639,
  parameter int         Y_MIN = 0,
  parameter int         Y_MAX = 479,
  parameter logic [9:0] STEP  = 10'd1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  output logic [9:0] Motion_X,
  output logic [9:0] Motion_Y,
  output logic       Update,
  output logic       Paused,
  output logic       Busy,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    APPLY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_A = 2'd0,
    DIR_D = 2'd1,
    DIR_W = 2'd2,
    DIR_S = 2'd3
  } dir_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic [9:0]         STEP_N  = -STEP;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_fs1;
  logic       r_fs2;
  logic       r_fs3;
  logic       r_frame_tick;
  logic [7:0] r_key_prev;
  dir_t       r_pend_dir;
  logic       r_pend_valid;
  logic       r_pend_pause;
  logic [9:0] r_motion_x;
  logic [9:0] r_motion_y;
  logic       r_update;
  logic       r_paused;

  logic       w_key_dir;
  dir_t       w_key_dir_val;
  logic       w_space_edge;
  logic       w_paused_nxt;
  logic       w_take_dir;
  logic [9:0] w_cand_x;
  logic [9:0] w_cand_y;
  logic [9:0] w_clamp_x;
  logic [9:0] w_clamp_y;
  logic signed [10:0] w_x_lo;
  logic signed [10:0] w_x_hi;
  logic signed [10:0] w_y_lo;
  logic signed [10:0] w_y_hi;

  // Reflect a component that points into a wall the ball already touches.
  // A zero component is left alone.
  function automatic logic [9:0] clamp_axis(
    input logic [9:0]         cand,
    input logic signed [10:0] lo,
    input logic signed [10:0] hi,
    input logic signed [10:0] lim_lo,
    input logic signed [10:0] lim_hi
  );
    logic [9:0] res;
    res = cand;
    if (cand[9] && (lo <= lim_lo)) begin
      res = STEP;
    end else if (!cand[9] && (cand != 10'd0) && (hi >= lim_hi)) begin
      res = STEP_N;
    end
    return res;
  endfunction

  // Frame clock synchronizer and rising-edge detect. The tick is registered,
  // so it lands three Clk after the frame_clk rise.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_fs1        <= 1'b0;
      r_fs2        <= 1'b0;
      r_fs3        <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_fs1        <= frame_clk;
      r_fs2        <= r_fs1;
      r_fs3        <= r_fs2;
      r_frame_tick <= r_fs2 & ~r_fs3;
    end
  end

  // Key decode.
  always_comb begin
    w_key_dir     = 1'b1;
    w_key_dir_val = DIR_A;
    case (keycode)
      KEY_A:   w_key_dir_val = DIR_A;
      KEY_D:   w_key_dir_val = DIR_D;
      KEY_W:   w_key_dir_val = DIR_W;
      KEY_S:   w_key_dir_val = DIR_S;
      default: w_key_dir     = 1'b0;
    endcase
  end

  assign w_space_edge = (keycode == KEY_SPACE) && (r_key_prev != KEY_SPACE);

  // Evaluation datapath, used only in EVAL. The direction key is honoured
  // against the pause state after this frame's toggle, so an unpausing
  // frame already moves in the newly pressed direction.
  assign w_paused_nxt = r_paused ^ r_pend_pause;
  assign w_take_dir   = r_pend_valid && !w_paused_nxt;

  always_comb begin
    w_cand_x = r_motion_x;
    w_cand_y = r_motion_y;
    if (w_take_dir) begin
      w_cand_x = 10'd0;
      w_cand_y = 10'd0;
      case (r_pend_dir)
        DIR_A:   w_cand_x = STEP_N;
        DIR_D:   w_cand_x = STEP;
        DIR_W:   w_cand_y = STEP_N;
        default: w_cand_y = STEP;
      endcase
    end
  end

  // Widen to 11-bit signed, so a small ball near the origin cannot wrap.
  assign w_x_lo = $signed({1'b0, BallX}) - $signed({1'b0, BallS});
  assign w_x_hi = $signed({1'b0, BallX}) + $signed({1'b0, BallS});
  assign w_y_lo = $signed({1'b0, BallY}) - $signed({1'b0, BallS});
  assign w_y_hi = $signed({1'b0, BallY}) + $signed({1'b0, BallS});

  assign w_clamp_x = clamp_axis(w_cand_x, w_x_lo, w_x_hi, X_MIN_S, X_MAX_S);
  assign w_clamp_y = clamp_axis(w_cand_y, w_y_lo, w_y_hi, Y_MIN_S, Y_MAX_S);

  // FSM next state. A tick outside IDLE is dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_frame_tick) w_state_nxt = EVAL;
      EVAL:    w_state_nxt = APPLY;
      APPLY:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending key capture. A fresh capture overrides a clear in the same
  // cycle, so the new key stays pending for the next frame.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_key_prev   <= 8'h00;
      r_pend_dir   <= DIR_A;
      r_pend_valid <= 1'b0;
      r_pend_pause <= 1'b0;
    end else begin
      r_key_prev <= keycode;
      if (w_key_dir) begin
        r_pend_dir   <= w_key_dir_val;
        r_pend_valid <= 1'b1;
      end else if ((r_state == EVAL) && w_take_dir) begin
        r_pend_valid <= 1'b0;
      end
      if (w_space_edge) begin
        r_pend_pause <= 1'b1;
      end else if (r_state == EVAL) begin
        r_pend_pause <= 1'b0;
      end
    end
  end

  // Motion and strobe are loaded as EVAL ends, so they are valid for the
  // whole APPLY cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_motion_x <= 10'd0;
      r_motion_y <= 10'd0;
      r_update   <= 1'b0;
      r_paused   <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (r_state == EVAL) begin
        r_paused   <= w_paused_nxt;
        r_motion_x <= w_clamp_x;
        r_motion_y <= w_clamp_y;
        r_update   <= !w_paused_nxt;
      end
    end
  end

  assign Motion_X    = r_motion_x;
  assign Motion_Y    = r_motion_y;
  assign Update      = r_update;
  assign Paused      = r_paused;
  assign Busy        = (r_state == EVAL) || (r_state == APPLY);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
module tb_ball_motion_ctrl;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] BallS;
  logic [9:0] Motion_X;
  logic [9:0] Motion_Y;
  logic       Update;
  logic       Paused;
  logic       Busy;
  logic [1:0] o_dbg_state;

  int n_vec;
  int n_err;

  // Reference model state, kept as plain integers.
  int m_mx;
  int m_my;
  int m_paused;
  int m_pend_valid;
  int m_pend_dir;
  int m_pend_pause;
  int m_prev_key;

  logic [9:0] exp_q[$];

  ball_motion_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .BallX      (BallX),
    .BallY      (BallY),
    .BallS      (BallS),
    .Motion_X   (Motion_X),
    .Motion_Y   (Motion_Y),
    .Update     (Update),
    .Paused     (Paused),
    .Busy       (Busy),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_mx = 0; m_my = 0; m_paused = 0;
    m_pend_valid = 0; m_pend_dir = 0; m_pend_pause = 0; m_prev_key = 0;
  endtask

  task automatic model_key(input int k);
    if (k == 'h04 || k == 'h07 || k == 'h16 || k == 'h1A) begin
      m_pend_dir = k;
      m_pend_valid = 1;
    end
    if (k == 'h2C && m_prev_key != 'h2C) m_pend_pause = 1;
    m_prev_key = k;
  endtask

  // One frame: returns whether an update is expected.
  task automatic model_frame(output int upd);
    int cx, cy, bx, by, bs;
    bx = int'(BallX); by = int'(BallY); bs = int'(BallS);
    if (m_pend_pause != 0) begin
      m_paused = 1 - m_paused;
      m_pend_pause = 0;
    end
    cx = m_mx; cy = m_my;
    if (m_pend_valid != 0 && m_paused == 0) begin
      cx = 0; cy = 0;
      case (m_pend_dir)
        'h04: cx = -1;
        'h07: cx = 1;
        'h1A: cy = -1;
        default: cy = 1;
      endcase
      m_pend_valid = 0;
    end
    if (cx < 0 && (bx - bs) <= 0)   cx = 1;
    if (cx > 0 && (bx + bs) >= 639) cx = -1;
    if (cy < 0 && (by - bs) <= 0)   cy = 1;
    if (cy > 0 && (by + bs) >= 479) cy = -1;
    m_mx = cx; m_my = cy;
    upd = (m_paused == 0) ? 1 : 0;
  endtask

  // ---------------- drivers ----------------
  task automatic press_key(input logic [7:0] k);
    @(negedge Clk);
    keycode = k;
    model_key(int'(k));
    @(negedge Clk);
    keycode = 8'h00;
    model_key(0);
  endtask

  task automatic hold_key(input logic [7:0] k);
    @(negedge Clk);
    keycode = k;
    model_key(int'(k));
  endtask

  // Pulse frame_clk, watch 14 cycles, check against the model.
  task automatic run_frame(input string tag);
    int n_upd, first_c, exp_upd;
    logic [9:0] mx_at, my_at, ex, ey;
    n_upd = 0; first_c = -1; mx_at = '0; my_at = '0;
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      if (c == 7) frame_clk = 1'b0;
      if (Update === 1'b1) begin
        n_upd++;
        if (first_c < 0) first_c = c;
        mx_at = Motion_X; my_at = Motion_Y;
      end
    end
    model_frame(exp_upd);
    ex = 10'(m_mx); ey = 10'(m_my);
    exp_q.push_back({ex});
    n_vec++;
    if (n_upd !== exp_upd) begin
      n_err++;
      $display("FAIL %s update_count got %0d want %0d", tag, n_upd, exp_upd);
    end
    if (exp_upd == 1) begin
      n_vec++;
      if (first_c < 4 || first_c > 6) begin
        n_err++;
        $display("FAIL %s update_latency got %0d want 5", tag, first_c);
      end
      n_vec++;
      if (mx_at !== ex || my_at !== ey) begin
        n_err++;
        $display("FAIL %s motion_at_update got %h/%h want %h/%h", tag, mx_at, my_at, ex, ey);
      end
    end
    n_vec++;
    if (Motion_X !== exp_q.pop_front() || Motion_Y !== ey) begin
      n_err++;
      $display("FAIL %s motion_hold got %h/%h want %h/%h", tag, Motion_X, Motion_Y, ex, ey);
    end
    n_vec++;
    if (Paused !== 1'(m_paused) || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s paused_busy got %b/%b want %b/0", tag, Paused, Busy, 1'(m_paused));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0; frame_clk = 1'b0; keycode = 8'h00;
    BallX = 10'd320; BallY = 10'd240; BallS = 10'd4;
    model_reset();
    repeat (4) @(negedge Clk);
    n_vec++;
    if (Motion_X !== 10'd0 || Motion_Y !== 10'd0 || Update !== 1'b0 ||
        Paused !== 1'b0 || Busy !== 1'b0 || o_dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs got mx=%h my=%h u=%b p=%b b=%b st=%0d want all 0",
               Motion_X, Motion_Y, Update, Paused, Busy, o_dbg_state);
    end
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_idle_frames();
    for (int i = 0; i < 3; i++) run_frame("idle");
  endtask

  task automatic test_dir_key();
    press_key(8'h07);
    run_frame("key_d");
    run_frame("key_d_hold1");
    run_frame("key_d_hold2");
  endtask

  task automatic test_wall_bounce();
    BallX = 10'd635; BallS = 10'd4;
    run_frame("right_wall");
    BallX = 10'd4;
    run_frame("left_wall");
    BallX = 10'd320;
  endtask

  task automatic test_underflow();
    BallY = 10'd2; BallS = 10'd4;
    press_key(8'h1A);
    run_frame("top_underflow");
    run_frame("top_underflow2");
    BallY = 10'd240;
  endtask

  task automatic test_pause();
    hold_key(8'h2C);
    for (int i = 0; i < 10; i++) run_frame("paused_hold");
    hold_key(8'h04);
    hold_key(8'h00);
    hold_key(8'h2C);
    run_frame("unpause_left");
    hold_key(8'h00);
    run_frame("after_unpause");
  endtask

  task automatic test_back_to_back();
    int n_upd, exp_upd;
    n_upd = 0;
    press_key(8'h16);
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk); frame_clk = 1'b0;
    @(negedge Clk); frame_clk = 1'b1;
    if (Update === 1'b1) n_upd++;
    @(negedge Clk); frame_clk = 1'b0;
    if (Update === 1'b1) n_upd++;
    for (int c = 0; c < 14; c++) begin
      @(negedge Clk);
      if (Update === 1'b1) n_upd++;
    end
    model_frame(exp_upd);
    n_vec++;
    if (n_upd !== exp_upd) begin
      n_err++;
      $display("FAIL back_to_back update_count got %0d want %0d", n_upd, exp_upd);
    end
    n_vec++;
    if (Motion_X !== 10'(m_mx) || Motion_Y !== 10'(m_my)) begin
      n_err++;
      $display("FAIL back_to_back motion got %h/%h want %h/%h",
               Motion_X, Motion_Y, 10'(m_mx), 10'(m_my));
    end
  endtask

  task automatic test_reset_mid_apply();
    int found, n_upd;
    found = 0; n_upd = 0;
    press_key(8'h04);
    @(negedge Clk); frame_clk = 1'b1;
    for (int c = 0; c < 12 && found == 0; c++) begin
      @(negedge Clk);
      if (Update === 1'b1) found = 1;
    end
    n_vec++;
    if (found == 0) begin
      n_err++;
      $display("FAIL reset_apply no_update_seen got 0 want 1");
    end
    Reset = 1'b0;
    #1;
    n_vec++;
    if (Update !== 1'b0 || Motion_X !== 10'd0 || Motion_Y !== 10'd0 ||
        Busy !== 1'b0 || o_dbg_state !== 2'd0 || Paused !== 1'b0) begin
      n_err++;
      $display("FAIL reset_apply outputs got u=%b mx=%h my=%h b=%b st=%0d want 0",
               Update, Motion_X, Motion_Y, Busy, o_dbg_state);
    end
    frame_clk = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (Update === 1'b1) n_upd++;
    end
    n_vec++;
    if (n_upd !== 0) begin
      n_err++;
      $display("FAIL reset_apply stray_update got %0d want 0", n_upd);
    end
    run_frame("post_reset");
  endtask

  task automatic test_random();
    logic [7:0] keys[6];
    keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07;
    keys[3] = 8'h16; keys[4] = 8'h1A; keys[5] = 8'h2C;
    for (int i = 0; i < 40; i++) begin
      BallS = 10'($urandom_range(0, 12));
      case ($urandom_range(0, 3))
        0: BallX = 10'($urandom_range(0, 10));
        1: BallX = 10'($urandom_range(628, 639));
        default: BallX = 10'($urandom_range(0, 639));
      endcase
      case ($urandom_range(0, 3))
        0: BallY = 10'($urandom_range(0, 10));
        1: BallY = 10'($urandom_range(468, 479));
        default: BallY = 10'($urandom_range(0, 479));
      endcase
      press_key(keys[$urandom_range(0, 5)]);
      if ($urandom_range(0, 2) == 0) press_key(keys[$urandom_range(1, 4)]);
      run_frame("random");
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_idle_frames();
    test_dir_key();
    test_wall_bounce();
    test_underflow();
    test_pause();
    test_back_to_back();
    test_reset_mid_apply();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
